// File: rtl/rf_pkg.sv
// Shared types and defaults for the 8x32 register file: width/depth defaults,
// clear-engine state encoding and the hardwired-zero register address.
package rf_pkg;

    localparam int RF_XLEN = 32;
    localparam int RF_NREG = 8;
    localparam int RF_AW   = $clog2(RF_NREG);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        DONE  = 2'b10
    } rf_state_e;

    localparam logic [RF_AW-1:0] ZERO_REG = {RF_AW{1'b0}};

endpackage

// File: rtl/reg_file_8x32_if.sv
// Write, read and clear-control bundle of the register file.
// The master modport drives requests and addresses; the slave modport is the register file.
interface reg_file_8x32_if
    import rf_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int AW   = RF_AW
);

    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic            wr_ready;
    logic [AW-1:0]   raddr1;
    logic [XLEN-1:0] rdata1;
    logic [AW-1:0]   raddr2;
    logic [XLEN-1:0] rdata2;
    logic            clr_req;
    logic            busy;
    logic            clr_done;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, clr_req,
        input  wr_ready, rdata1, rdata2, busy, clr_done
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, clr_req,
        output wr_ready, rdata1, rdata2, busy, clr_done
    );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: word select built from per-bit NREG:1 selection,
// with the x0 zero-force and, when RF_BYPASS_EN is defined, write-to-read forwarding.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int NREG = RF_NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic [NREG-1:0][XLEN-1:0] regs,
    input  logic [AW-1:0]             raddr,
    input  logic                      wr_acc,
    input  logic [AW-1:0]             waddr,
    input  logic [XLEN-1:0]           wdata,
    output logic [XLEN-1:0]           rdata
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [XLEN-1:0] sel_s;

    for (genvar b = 0; b < XLEN; b++) begin : g_bit
        logic [NREG-1:0] col_s;
        for (genvar r = 0; r < NREG; r++) begin : g_row
            assign col_s[r] = regs[r][b];
        end
        assign sel_s[b] = col_s[raddr];
    end

`ifndef RF_BYPASS_EN
    logic unused_bypass_s;
    assign unused_bypass_s = ^{wr_acc, waddr, wdata};
`endif

    // Final read mux: x0 reads zero; an accepted write to the same address can forward.
    always_comb begin
        rdata = sel_s;
        if (raddr == ZERO_ADDR) begin
            rdata = {XLEN{1'b0}};
        end
`ifdef RF_BYPASS_EN
        else if (wr_acc && (waddr == raddr)) begin
            rdata = wdata;
        end
`endif
        else begin
            rdata = sel_s;
        end
    end

endmodule

// File: rtl/reg_file_8x32.sv
// 8-entry register file with x0 hardwired to zero, one write port, two read ports and a
// sequential clear engine. Define RF_BYPASS_EN to forward accepted writes to the read ports.
module reg_file_8x32
    import rf_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int NREG = RF_NREG
) (
    input  logic            clk,
    input  logic            rst,
    reg_file_8x32_if.slave  bus
);

    localparam int            AW        = $clog2(NREG);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);
    localparam logic [AW-1:0] ONE_ADDR  = AW'(1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

    logic [NREG-1:0][XLEN-1:0] regs_r;
    rf_state_e                 state_r;
    rf_state_e                 state_s;
    logic [AW-1:0]             cnt_r;
    logic [AW-1:0]             cnt_s;
    logic                      busy_r;
    logic                      clr_done_r;
    logic                      wr_acc_s;
    logic                      clr_en_s;

    // Writes are refused while the sweep owns the storage; x0 is never written.
    assign wr_acc_s = bus.we && !busy_r && (bus.waddr != ZERO_ADDR);
    assign clr_en_s = (state_r == CLEAR);

    // Clear-engine next state and sweep counter.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE, DONE: begin
                if (bus.clr_req) begin
                    state_s = CLEAR;
                    cnt_s   = ONE_ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: begin
                if (cnt_r == LAST_ADDR) begin
                    state_s = DONE;
                end else begin
                    cnt_s = cnt_r + ONE_ADDR;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = ONE_ADDR;
            end
        endcase
    end

    // State register; status flags are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= ONE_ADDR;
            busy_r     <= 1'b0;
            clr_done_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            busy_r     <= (state_s == CLEAR);
            clr_done_r <= (state_s == DONE);
        end
    end

    // Storage: the sweep and the write port are mutually exclusive because writes need !busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_r <= '0;
        end else if (clr_en_s) begin
            regs_r[cnt_r] <= {XLEN{1'b0}};
        end else if (wr_acc_s) begin
            regs_r[bus.waddr] <= bus.wdata;
        end
    end

    assign bus.wr_ready = !busy_r;
    assign bus.busy     = busy_r;
    assign bus.clr_done = clr_done_r;

    rf_read_port #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW)
    ) u_read_port1 (
        .regs   (regs_r),
        .raddr  (bus.raddr1),
        .wr_acc (wr_acc_s),
        .waddr  (bus.waddr),
        .wdata  (bus.wdata),
        .rdata  (bus.rdata1)
    );

    rf_read_port #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW)
    ) u_read_port2 (
        .regs   (regs_r),
        .raddr  (bus.raddr2),
        .wr_acc (wr_acc_s),
        .waddr  (bus.waddr),
        .wdata  (bus.wdata),
        .rdata  (bus.rdata2)
    );

endmodule

// File: tb/tb_reg_file_8x32.sv
// Scoreboard bench for reg_file_8x32: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_file_8x32;
    import rf_pkg::*;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int SEL_RD1 = 0;
    localparam int SEL_RD2 = 1;
    localparam int SEL_BSY = 2;
    localparam int SEL_WRR = 3;
    localparam int SEL_DON = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_8x32_if #(.XLEN(32), .AW(3)) bus ();

    reg_file_8x32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sb_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_RD1: return bus.rdata1;
            SEL_RD2: return bus.rdata2;
            SEL_BSY: return {31'd0, bus.busy};
            SEL_WRR: return {31'd0, bus.wr_ready};
            SEL_DON: return {31'd0, bus.clr_done};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        chk_t        e;
        logic [31:0] act;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e   = sb_q.pop_front();
            act = observe(e.sel);
            n_checks++;
            if (e.cyc != cyc || act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h (cycle %0d, due %0d)",
                         e.name, act, e.exp, cyc, e.cyc);
            end
        end
    end

    task automatic chk(input int sel, input logic [31:0] exp, input string name);
        chk_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        bus.we      = 1'b0;
        bus.waddr   = 3'd0;
        bus.wdata   = 32'd0;
        bus.raddr1  = 3'd0;
        bus.raddr2  = 3'd0;
        bus.clr_req = 1'b0;

        // Reset asserted mid-cycle, released after two edges.
        #3 rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk(SEL_BSY, 32'd0, "rst_busy");
        chk(SEL_WRR, 32'd1, "rst_wr_ready");
        chk(SEL_DON, 32'd0, "rst_clr_done");
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            bus.raddr1 = 3'(i);
            bus.raddr2 = 3'(7 - i);
            chk(SEL_RD1, 32'd0, "rst_rd1");
            chk(SEL_RD2, 32'd0, "rst_rd2");
        end

        // Basic write and write to x0.
        step();
        bus.we = 1'b1; bus.waddr = 3'd5; bus.wdata = 32'hDEAD_BEEF; bus.raddr1 = 3'd5;
        chk(SEL_RD1, BYP ? 32'hDEAD_BEEF : 32'd0, "wr5_same_cycle");
        step();
        bus.we = 1'b0;
        chk(SEL_RD1, 32'hDEAD_BEEF, "wr5_next_cycle");
        step();
        bus.we = 1'b1; bus.waddr = 3'd0; bus.wdata = 32'h1234_5678; bus.raddr2 = 3'd0;
        chk(SEL_RD2, 32'd0, "wr0_same_cycle");
        step();
        bus.we = 1'b0;
        chk(SEL_RD2, 32'd0, "wr0_next_cycle");

        // Preload 1..7 then sweep, with a dropped write during busy.
        for (int i = 1; i < 8; i++) begin
            step();
            bus.we = 1'b1; bus.waddr = 3'(i); bus.wdata = 32'h11 * 32'(i);
        end
        step();
        bus.we = 1'b0; bus.raddr1 = 3'd3; bus.raddr2 = 3'd7;
        chk(SEL_RD1, 32'h33, "preload_r3");
        chk(SEL_RD2, 32'h77, "preload_r7");
        step();
        bus.clr_req = 1'b1;
        chk(SEL_BSY, 32'd0, "clr_req_cycle_busy");
        chk(SEL_DON, 32'd0, "clr_req_cycle_done");
        for (int k = 1; k < 8; k++) begin
            step();
            bus.clr_req = 1'b0;
            bus.we      = (k == 1);
            bus.waddr   = 3'd3;
            bus.wdata   = 32'hFFFF_FFFF;
            bus.raddr1  = 3'd3;
            bus.raddr2  = 3'(k);
            chk(SEL_BSY, 32'd1, "sweep_busy");
            chk(SEL_WRR, 32'd0, "sweep_wr_ready");
            chk(SEL_DON, 32'd0, "sweep_no_done");
            chk(SEL_RD1, (k <= 3) ? 32'h33 : 32'd0, "sweep_r3");
            chk(SEL_RD2, 32'h11 * 32'(k), "sweep_rcnt_old");
        end
        step();
        bus.we = 1'b0;
        chk(SEL_BSY, 32'd0, "done_busy");
        chk(SEL_DON, 32'd1, "done_pulse");
        chk(SEL_WRR, 32'd1, "done_wr_ready");
        step();
        chk(SEL_DON, 32'd0, "idle_after_done");
        chk(SEL_BSY, 32'd0, "idle_busy");
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            bus.raddr1 = 3'(i);
            chk(SEL_RD1, 32'd0, "post_sweep_zero");
        end

        // clr_req together with a write in IDLE; restart from DONE; reset mid-sweep.
        step();
        bus.clr_req = 1'b1; bus.we = 1'b1; bus.waddr = 3'd2; bus.wdata = 32'hAAAA_0000;
        chk(SEL_WRR, 32'd1, "clr_and_wr_ready");
        for (int k = 1; k < 8; k++) begin
            step();
            bus.clr_req = 1'b0; bus.we = 1'b0; bus.raddr1 = 3'd2;
            chk(SEL_RD1, (k <= 2) ? 32'hAAAA_0000 : 32'd0, "clr_wr_r2");
            chk(SEL_BSY, 32'd1, "clr_wr_busy");
        end
        step();
        chk(SEL_DON, 32'd1, "done2_pulse");
        chk(SEL_WRR, 32'd1, "done2_wr_ready");
        bus.clr_req = 1'b1; bus.we = 1'b1; bus.waddr = 3'd7; bus.wdata = 32'h77;
        step();
        bus.clr_req = 1'b0; bus.we = 1'b0; bus.raddr1 = 3'd7; bus.raddr2 = 3'd2;
        chk(SEL_BSY, 32'd1, "restart_busy");
        chk(SEL_RD1, 32'h77, "done_write_r7");
        chk(SEL_RD2, 32'd0, "restart_r2");
        step();
        step();
        chk(SEL_RD1, 32'h77, "pre_reset_r7");
        step();
        rst = 1'b1;
        chk(SEL_RD1, 32'd0, "mid_reset_r7");
        chk(SEL_BSY, 32'd0, "mid_reset_busy");
        chk(SEL_WRR, 32'd1, "mid_reset_wr_ready");
        for (int j = 0; j < 9; j++) begin
            step();
            if (j == 0) rst = 1'b0;
            chk(SEL_DON, 32'd0, "post_reset_no_done");
            chk(SEL_BSY, 32'd0, "post_reset_busy");
        end

        // Forwarding behaviour (or its absence) and x0 bypass attempt.
        step();
        bus.we = 1'b1; bus.waddr = 3'd4; bus.wdata = 32'h4444_4444;
        step();
        bus.wdata = 32'hCAFE_F00D; bus.raddr1 = 3'd4;
        chk(SEL_RD1, BYP ? 32'hCAFE_F00D : 32'h4444_4444, "bypass_same_cycle");
        step();
        bus.we = 1'b0;
        chk(SEL_RD1, 32'hCAFE_F00D, "bypass_next_cycle");
        step();
        bus.we = 1'b1; bus.waddr = 3'd0; bus.wdata = 32'h5555_5555;
        bus.raddr1 = 3'd0; bus.raddr2 = 3'd0;
        chk(SEL_RD1, 32'd0, "bypass_x0_rd1");
        chk(SEL_RD2, 32'd0, "bypass_x0_rd2");
        step();
        bus.we = 1'b0;

        // Drain the scoreboard within a bounded number of cycles.
        for (int w = 0; w < 5 && sb_q.size() > 0; w++) step();
        if (sb_q.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked, expected 0", sb_q.size());
            n_fail += sb_q.size();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
